dmem_io_mmap: RTL
=================

# dmem_io_mmap

Parametrised data memory with a memory-mapped I/O window, the next generation of the processor's data RAM. It sits on the CPU load/store port and keeps the same single-cycle write and combinational read contract. It adds generic width, depth and port count, two-flop input synchronisers, sticky change-detect status with an interrupt mask, and a hardware memory-clear sweep after reset.

## Interface
- DW, 8, data word width in bits.
- AW, 8, address width; the address space holds 2**AW words.
- N_IN, 3, number of input ports, 1..6; must not exceed DW.
- N_OUT, 4, number of output ports, 1..6.
- CLEAR_ON_RESET, 1, when 1, reset triggers the memory clear sweep.
- Derived: IO_BASE = 2**AW-16; MEM_WORDS = IO_BASE.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ADDR  in  AW  word address.
- DATA  in  DW  write data.
- MW  in  1  memory write strobe, one cycle per write.
- Q  out  DW  read data, combinational from ADDR and state.
- IN_PORTS  in  N_IN*DW  asynchronous inputs; port i is at bits [i*DW +: DW].
- OUT_PORTS  out  N_OUT*DW  output registers; port j is at bits [j*DW +: DW].
- IRQ  out  1  high when any status bit is set and its mask bit is set.
- BUSY  out  1  clear sweep in progress.

## Operation
- Address map (offset = ADDR-IO_BASE):
  - 0..5: synchronised input port i, read-only. Offsets with i>=N_IN read 0.
  - 6: STATUS; bits [N_IN-1:0] are sticky change flags, upper bits read 0. Writing 1 to a bit clears it.
  - 7: MASK; bits [N_IN-1:0] are read/write, upper bits read 0 and ignore writes.
  - 8..13: output register j, read/write. Offsets with j>=N_OUT read 0 and ignore writes.
  - 14, 15: reserved; read 0, writes ignored.
- ADDR < IO_BASE selects RAM. With MW=1, mem[ADDR] <= DATA at the clock edge. With MW=0, Q = mem[ADDR].
- Q is 0 on any cycle where MW=1, matching the existing load/store contract.
- Input path: sync1 <= IN_PORTS, sync2 <= sync1, prev <= sync2, per port.
  - Offset i reads sync2[i].
  - change[i] = (sync2[i] != prev[i]).
- STATUS update per bit:
  - next = (cur & ~(wr_status & DATA[i])) | change[i].
  - A set and a clear in the same cycle leave the bit set; the set wins.
- IRQ = |(STATUS & MASK), driven combinationally from registers.
- Clear sweep (only when CLEAR_ON_RESET=1). FSM states are IDLE and SWEEP, with a counter cnt of width AW.
  - RESET forces SWEEP and cnt=0 from any state.
  - In SWEEP with RESET low: mem[cnt] <= 0 and cnt <= cnt+1. When cnt == MEM_WORDS-1, the FSM moves to IDLE.
  - BUSY = (state == SWEEP).
  - During SWEEP, CPU RAM writes are dropped and RAM reads return 0. IO window accesses operate normally.
  - RESET during a sweep restarts it at cnt=0.
- CLEAR_ON_RESET=0: the FSM stays in IDLE, BUSY=0, and RAM contents survive reset.
- Reset values: OUT_PORTS=0, STATUS=0, MASK=0, sync1/sync2/prev=0, IRQ=0, BUSY=1 (0 if CLEAR_ON_RESET=0).
- Priority within a clock edge: RESET, then the sweep write, then the CPU write.

## Timing
- RAM and IO writes: visible on Q the cycle after the MW edge.
- Reads: combinational, zero-cycle latency.
- Input change to readable value: 2 clock edges.
- Input change to STATUS bit set: 3 edges. IRQ rises in the same cycle STATUS sets, if the mask bit is set.
- Sweep length: BUSY stays high for MEM_WORDS cycles after RESET falls (240 cycles at AW=8). The first CPU RAM write is accepted on the following cycle.
- Writing MASK updates IRQ in the cycle after the write edge.

## Test plan
- Sweep: preload mem[5]=0xAA with CLEAR_ON_RESET=0, then reset with CLEAR_ON_RESET=1.
  - Expect BUSY high for 240 cycles and mem[5] reading 0 afterwards.
  - A write to mem[5] during BUSY is dropped; a write after BUSY falls reads back.
- IO write/readback: write 0x5C to IO_BASE+9.
  - Expect OUT_PORTS[15:8]=0x5C and Q=0x5C when reading IO_BASE+9.
  - A write to IO_BASE+14 leaves all registers unchanged.
- Input synchronisation: step IN_PORTS port 1 from 0x00 to 0x3F.
  - Expect IO_BASE+1 to read 0x3F after exactly 2 edges.
  - Expect STATUS=0x02 after 3 edges, with IRQ staying 0 while MASK=0.
- Interrupt: set MASK=0x02 and raise a change on port 1.
  - Expect IRQ=1. Write 0x02 to STATUS; expect STATUS=0 and IRQ=0 on the next cycle.
- Simultaneous set and clear: time a W1C write to STATUS on the same edge as a new port-1 change.
  - Expect STATUS bit 1 to remain 1.
- Reset mid-sweep: assert RESET at cycle 100 of the sweep.
  - Expect cnt to restart and BUSY to stay high for a full 240 cycles after RESET falls.
  - Expect OUT_PORTS, STATUS, MASK and IRQ all 0.

Source files
------------

// File: rtl/dmem_io_mmap.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dmem_io_mmap
//
// This module is the processor data RAM with a 16-word memory-mapped I/O
// window at the top of the address space. A write takes one cycle. A read is
// combinational.
//
// After reset, a hardware sweep clears the RAM. This happens only when
// CLEAR_ON_RESET is 1.
//
// Address map (offset = ADDR - IO_BASE):
//   0..5   synchronised input port i (read-only, reads 0 when i >= N_IN)
//   6      STATUS : sticky change flags, write-1-to-clear
//   7      MASK   : interrupt enables
//   8..13  output register j (reads 0 and ignores writes when j >= N_OUT)
//   14,15  reserved, read 0
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      synchronous active-high reset
//   ADDR       word address
//   DATA       write data
//   MW         write strobe (Q reads 0 while MW is high)
//   Q          combinational read data
//   IN_PORTS   asynchronous inputs, port i at [i*DW +: DW]
//   OUT_PORTS  output registers, port j at [j*DW +: DW]
//   IRQ        any STATUS bit set with its MASK bit set
//   BUSY       clear sweep in progress
// ---------------------------------------------------------------------------
module dmem_io_mmap #(
    parameter int DW             = 8,
    parameter int AW             = 8,
    parameter int N_IN           = 3,
    parameter int N_OUT          = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [AW-1:0]         ADDR,
    input  logic [DW-1:0]         DATA,
    input  logic                  MW,
    output logic [DW-1:0]         Q,
    input  logic [N_IN*DW-1:0]    IN_PORTS,
    output logic [N_OUT*DW-1:0]   OUT_PORTS,
    output logic                  IRQ,
    output logic                  BUSY
);

    localparam int IO_BASE    = 2**AW - 16;
    localparam int MEM_WORDS  = IO_BASE;
    localparam int OFF_STATUS = 6;
    localparam int OFF_MASK   = 7;
    localparam int OFF_OUT0   = 8;
    localparam logic [AW-1:0] LAST_WORD = AW'(MEM_WORDS - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    // The I/O window is the top 16 words, so the upper address bits are all
    // ones exactly when the address is at or above IO_BASE.
    logic       io_sel;
    logic [3:0] offset;

    assign io_sel = &ADDR[AW-1:4];
    assign offset = ADDR[3:0];

    // -----------------------------------------------------------------------
    // Clear-sweep FSM
    // -----------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of block ordering.
    always_ff @(posedge CLK) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    // Reset is synchronous, so it is folded into the next-state logic. Reset
    // restarts the sweep from word 0 from any state, including mid-sweep.
    // NOTE: every combinational output gets a default first; a path that
    // leaves a variable unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (RESET) begin
            state_d = S_SWEEP;
            cnt_d   = '0;
        end else if (state_q == S_SWEEP) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == LAST_WORD) begin
                state_d = S_IDLE;
            end
        end
        // Without the clear feature the sweep never starts.
        if (CLEAR_ON_RESET == 0) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    assign BUSY = (state_q == S_SWEEP);

    // -----------------------------------------------------------------------
    // Write enables. The order of priority is reset, then the sweep write,
    // then the CPU write.
    // -----------------------------------------------------------------------
    logic sweep_we;
    logic ram_we;
    logic io_we;
    logic wr_status;
    logic wr_mask;

    assign sweep_we  = BUSY && !RESET;
    assign ram_we    = MW && !io_sel && !BUSY && !RESET;
    assign io_we     = MW && io_sel && !RESET;
    assign wr_status = io_we && (int'(offset) == OFF_STATUS);
    assign wr_mask   = io_we && (int'(offset) == OFF_MASK);

    // -----------------------------------------------------------------------
    // RAM
    // -----------------------------------------------------------------------
    logic [DW-1:0] mem [MEM_WORDS];

    // NOTE: the RAM array has no reset term. This keeps it mappable to block
    // RAM. Clearing the RAM is the job of the sweep, not of RESET.
    always_ff @(posedge CLK) begin
        if (sweep_we) begin
            mem[cnt_q] <= '0;
        end else if (ram_we) begin
            mem[ADDR] <= DATA;
        end
    end

    // -----------------------------------------------------------------------
    // Input synchronisers and change detection
    // -----------------------------------------------------------------------
    logic [N_IN*DW-1:0] sync1_q, sync2_q, prev_q;
    logic [N_IN-1:0]    change;

    always_comb begin
        change = '0;
        for (int i = 0; i < N_IN; i++) begin
            change[i] = |(sync2_q[i*DW +: DW] ^ prev_q[i*DW +: DW]);
        end
    end

    // -----------------------------------------------------------------------
    // STATUS / MASK / output registers
    // -----------------------------------------------------------------------
    logic [N_IN-1:0]     status_q, status_d;
    logic [N_IN-1:0]     mask_q, mask_d;
    logic [N_OUT*DW-1:0] out_q, out_d;

    // W1C clear and change-detect set can land on the same edge; OR-ing the
    // set in last makes the set win.
    always_comb begin
        status_d = '0;
        for (int i = 0; i < N_IN; i++) begin
            status_d[i] = (status_q[i] & ~(wr_status & DATA[i])) | change[i];
        end
    end

    assign mask_d = wr_mask ? DATA[N_IN-1:0] : mask_q;

    always_comb begin
        out_d = out_q;
        for (int j = 0; j < N_OUT; j++) begin
            if (io_we && (int'(offset) == OFF_OUT0 + j)) begin
                out_d[j*DW +: DW] = DATA;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            status_q <= '0;
            mask_q   <= '0;
            out_q    <= '0;
        end else begin
            sync1_q  <= IN_PORTS;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            status_q <= status_d;
            mask_q   <= mask_d;
            out_q    <= out_d;
        end
    end

    assign OUT_PORTS = out_q;
    assign IRQ       = |(status_q & mask_q);

    // -----------------------------------------------------------------------
    // Read path
    // -----------------------------------------------------------------------
    logic [DW-1:0] rd_io;

    // Unimplemented input/output slots and the reserved words fall through
    // to the zero default.
    always_comb begin
        rd_io = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (int'(offset) == i) begin
                rd_io = sync2_q[i*DW +: DW];
            end
        end
        if (int'(offset) == OFF_STATUS) begin
            rd_io[N_IN-1:0] = status_q;
        end
        if (int'(offset) == OFF_MASK) begin
            rd_io[N_IN-1:0] = mask_q;
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (int'(offset) == OFF_OUT0 + j) begin
                rd_io = out_q[j*DW +: DW];
            end
        end
    end

    // Q reads 0 on write cycles. RAM reads also return 0 while the sweep
    // runs, so the CPU never sees RAM that has only been partly cleared.
    always_comb begin
        if (MW) begin
            Q = '0;
        end else if (io_sel) begin
            Q = rd_io;
        end else if (BUSY) begin
            Q = '0;
        end else begin
            Q = mem[ADDR];
        end
    end

endmodule
